clk_div: RTL and testbench



---
 rtl/clk_div.sv | 37 +++
 tb/tb_clk_div.sv | 135 +++++++++++++
 2 files changed

// File: rtl/clk_div.sv
// Synchronous divide-by-DIVISOR square wave generator.
// Low phase first after reset; high phase gets the extra cycle when odd.
module clk_div #(
   parameter int DIVISOR = 4,
   parameter int CNT_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1
) (
   input  logic clk,
   input  logic reset,
   output logic clk_out
);

   if (DIVISOR < 2) begin : g_bad_divisor
      $error("clk_div: DIVISOR must be >= 2");
   end

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVISOR - 1);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(DIVISOR / 2);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   always_comb begin
      cnt_next = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
   end

   // Decode the next count so clk_out stays a pure register output.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         clk_out <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         clk_out <= (cnt_next >= HALF);
      end
   end

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div at DIVISOR 2, 4 and 5.
// All instances share clk and reset.
module tb_clk_div;

   logic clk;
   logic reset;
   logic out2;
   logic out4;
   logic out5;

   int n_run;
   int n_fail;

   clk_div #(.DIVISOR(2)) u2 (.clk(clk), .reset(reset), .clk_out(out2));
   clk_div #(.DIVISOR(4)) u4 (.clk(clk), .reset(reset), .clk_out(out4));
   clk_div #(.DIVISOR(5)) u5 (.clk(clk), .reset(reset), .clk_out(out5));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic edge_s();
      @(posedge clk);
      #1;
   endtask

   int pat2 [2];
   int pat4 [4];
   int pat5 [5];
   int hi4;
   int hi5;
   int r2;
   int r4;
   int r5;
   int p2;
   int p4;
   int p5;
   int max2;
   int max4;
   int max5;
   bit found;

   initial begin
      n_run  = 0;
      n_fail = 0;
      pat2 = '{1, 0};
      pat4 = '{0, 1, 1, 0};
      pat5 = '{0, 1, 1, 1, 0};
      reset = 1'b1;

      // reset held for 3 edges
      for (int i = 0; i < 3; i++) begin
         edge_s();
         chk("rst_out2", out2, 0);
         chk("rst_out4", out4, 0);
         chk("rst_out5", out5, 0);
         chk("rst_cnt4", int'(u4.cnt), 0);
         chk("rst_cnt5", int'(u5.cnt), 0);
      end

      @(negedge clk);
      reset = 1'b0;
      hi4 = 0;
      hi5 = 0;
      for (int i = 0; i < 20; i++) begin
         edge_s();
         chk("seq2", out2, pat2[i % 2]);
         chk("seq4", out4, pat4[i % 4]);
         chk("seq5", out5, pat5[i % 5]);
         hi4 += int'(out4);
         hi5 += int'(out5);
      end
      chk("high4", hi4, 10);
      chk("high5", hi5, 12);

      // reset in the middle of a high phase of the /4 instance
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         edge_s();
         if (out4 === 1'b1) found = 1'b1;
      end
      chk("find_high4", int'(found), 1);
      @(negedge clk);
      reset = 1'b1;
      edge_s();
      chk("mid_rst_out4", out4, 0);
      chk("mid_rst_cnt4", int'(u4.cnt), 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         edge_s();
         chk("restart4", out4, pat4[i % 4]);
         chk("restart5", out5, pat5[i % 5]);
      end

      // long run: rising-edge counts and counter range
      @(negedge clk);
      reset = 1'b1;
      edge_s();
      @(negedge clk);
      reset = 1'b0;
      r2 = 0; r4 = 0; r5 = 0;
      p2 = 0; p4 = 0; p5 = 0;
      max2 = 0; max4 = 0; max5 = 0;
      for (int i = 0; i < 1000; i++) begin
         edge_s();
         if (out2 && p2 == 0) r2++;
         if (out4 && p4 == 0) r4++;
         if (out5 && p5 == 0) r5++;
         p2 = int'(out2);
         p4 = int'(out4);
         p5 = int'(out5);
         if (int'(u2.cnt) > max2) max2 = int'(u2.cnt);
         if (int'(u4.cnt) > max4) max4 = int'(u4.cnt);
         if (int'(u5.cnt) > max5) max5 = int'(u5.cnt);
      end
      chk("rises2", r2, 500);
      chk("rises4", r4, 250);
      chk("rises5", r5, 200);
      chk("maxcnt2", max2, 1);
      chk("maxcnt4", max4, 3);
      chk("maxcnt5", max5, 4);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
